// File: rtl/debounce_pkg.sv
// Shared types and LFSR helpers for the contact-bounce stimulus generator.
package debounce_pkg;
  localparam int LFSR_W = 8;
  // x^8 + x^6 + x^5 + x^4 + 1, feedback shifted into bit 0
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {STABLE, BOUNCE, HOLD} state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/bounce_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; a zero seed is replaced by 1 so it never locks up.
module bounce_lfsr
  import debounce_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] o_lfsr
);
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] r_lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lfsr <= SEED_EFF;
    else       r_lfsr <= lfsr_next(r_lfsr);
  end

  assign o_lfsr = r_lfsr;
endmodule

// File: rtl/debounce_bounce_gen.sv
// Contact-bounce generator: turns each level change into a pseudo-random toggle burst.
// Optional BOUNCE_GEN_GLITCH_EN adds glitch_req for single-cycle glitches while stable.
module debounce_bounce_gen
  import debounce_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 8'hA5,
  parameter int                MAX_BOUNCES = 7,
  parameter int                DWELL_W     = 4,
  parameter int                SETTLE_CYC  = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
`ifdef BOUNCE_GEN_GLITCH_EN
  input  logic glitch_req,
`endif
  output logic bounce_out,
  output logic busy,
  output logic settled
);
  localparam int TOG_W  = $clog2(2 * MAX_BOUNCES + 2);
  localparam int HOLD_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(SETTLE_CYC - 1);

  // Odd toggle count so the burst always finishes on the new level.
  function automatic logic [TOG_W-1:0] burst_len(input logic [2:0] k_raw);
    int k;
    k = (int'(k_raw) > MAX_BOUNCES) ? MAX_BOUNCES : int'(k_raw);
    return TOG_W'(2 * k + 1);
  endfunction

  function automatic logic [DWELL_W-1:0] dwell_of(input logic [LFSR_W-1:0] s);
    return s[DWELL_W-1:0] | DWELL_W'(1);
  endfunction

  logic [LFSR_W-1:0]  w_lfsr;
  logic               w_unused_lfsr;
  state_t             r_state, w_state_nxt;
  logic               r_bounce, w_bounce_nxt;
  logic [TOG_W-1:0]   r_tog, w_tog_nxt;
  logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
  logic [HOLD_W-1:0]  r_hold, w_hold_nxt;
  logic               r_settled, w_settled_nxt;
`ifdef BOUNCE_GEN_GLITCH_EN
  logic               r_glitch, w_glitch_nxt;
`endif

  bounce_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .o_lfsr (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= STABLE;
      r_bounce  <= 1'b0;
      r_tog     <= '0;
      r_dwell   <= '0;
      r_hold    <= '0;
      r_settled <= 1'b0;
`ifdef BOUNCE_GEN_GLITCH_EN
      r_glitch  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_bounce  <= w_bounce_nxt;
      r_tog     <= w_tog_nxt;
      r_dwell   <= w_dwell_nxt;
      r_hold    <= w_hold_nxt;
      r_settled <= w_settled_nxt;
`ifdef BOUNCE_GEN_GLITCH_EN
      r_glitch  <= w_glitch_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bounce_nxt  = r_bounce;
    w_tog_nxt     = r_tog;
    w_dwell_nxt   = r_dwell;
    w_hold_nxt    = r_hold;
    w_settled_nxt = 1'b0;
`ifdef BOUNCE_GEN_GLITCH_EN
    w_glitch_nxt  = 1'b0;
`endif
    case (r_state)
      STABLE: begin
`ifdef BOUNCE_GEN_GLITCH_EN
        // Restore cycle after a glitch; level compare resumes next cycle.
        if (r_glitch) begin
          w_bounce_nxt = ~r_bounce;
        end else
`endif
        if (level_in != r_bounce) begin
          w_tog_nxt   = burst_len(w_lfsr[2:0]);
          w_dwell_nxt = dwell_of(w_lfsr);
          w_state_nxt = BOUNCE;
        end
`ifdef BOUNCE_GEN_GLITCH_EN
        else if (glitch_req) begin
          w_bounce_nxt = ~r_bounce;
          w_glitch_nxt = 1'b1;
        end
`endif
      end
      BOUNCE: begin
        if (r_dwell == DWELL_W'(1)) begin
          w_bounce_nxt = ~r_bounce;
          w_tog_nxt    = r_tog - TOG_W'(1);
          w_dwell_nxt  = dwell_of(w_lfsr);
          if (r_tog == TOG_W'(1)) begin
            w_state_nxt = HOLD;
            w_hold_nxt  = HOLD_INIT;
          end
        end else begin
          w_dwell_nxt = r_dwell - DWELL_W'(1);
        end
      end
      HOLD: begin
        if (r_hold == '0) begin
          w_settled_nxt = 1'b1;
          w_state_nxt   = STABLE;
        end else begin
          w_hold_nxt = r_hold - HOLD_W'(1);
        end
      end
      default: w_state_nxt = STABLE;
    endcase
  end

  assign bounce_out = r_bounce;
  assign busy       = (r_state != STABLE);
  assign settled    = r_settled;
endmodule
